// File: rtl/rotated_patch_orient_hist.sv
// rotated_patch_orient_hist
//   Takes the raster stream of rotated, bilinear-sampled patch pixels and
//   stores one winW x winH patch. It then computes a central-difference
//   gradient at every pixel and adds the gradient magnitude into an
//   8-direction orientation histogram for each cellW x cellW cell. The packed
//   histograms form the descriptor that goes to SIFT normalisation.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset; takes priority over en
//   en          clock enable; no state changes while low
//   start       begin a new patch: clears histograms and counters, enters LOAD
//   pix_valid   pix_in carries a pixel this cycle
//   pix_in      sampled pixel, raster order (row 0 first, x ascending)
//   busy        high while in LOAD or GRAD
//   desc_valid  high while in DONE. The pulse is normally one cycle long and
//               lasts longer if en is low
//   desc_out    descriptor, hist[c][b] at [(c*binN+b)*histW +: histW]
//
// Input handshake: the input has no backpressure. A pixel is taken on a
// rising clock edge where en=1, pix_valid=1, start=0 and the FSM is in LOAD.
// pix_valid is ignored in every other case.
//
// Timing with en held high: if the last pixel is taken in cycle t, GRAD
// visits one pixel per cycle in cycles t+1..t+N, and DONE (desc_valid) is
// cycle t+N+1.

module rotated_patch_orient_hist #(
  parameter int winW  = 4,
  parameter int winH  = winW,
  parameter int dataW = 8,
  parameter int cellW = 2,
  parameter int binN  = 8,
  parameter int histW = 12
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            en,
  input  logic                                            start,
  input  logic                                            pix_valid,
  input  logic [dataW-1:0]                                pix_in,
  output logic                                            busy,
  output logic                                            desc_valid,
  output logic [(winW/cellW)*(winH/cellW)*binN*histW-1:0] desc_out
);

  localparam int N     = winW * winH;
  localparam int IW    = $clog2(N);
  localparam int XW    = $clog2(winW);
  localparam int YW    = $clog2(winH);
  localparam int CX    = winW / cellW;
  localparam int CELLS = CX * (winH / cellW);
  localparam int HN    = CELLS * binN;
  localparam int HW    = $clog2(HN);
  localparam int DW    = HN * histW;
  localparam int MW    = dataW + 2;
  localparam int SW    = ((histW > MW) ? histW : MW) + 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(winW - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(winH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GRAD = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [histW-1:0] hist_q [HN];
  logic [histW-1:0] hist_d [HN];
  logic [DW-1:0]    desc_q, desc_d;
  logic [dataW-1:0] patch_q [N];
  logic             load_we;

  // Patch storage index for a (y, x) position.
  function automatic logic [IW-1:0] pidx(input logic [YW-1:0] yy,
                                         input logic [XW-1:0] xx);
    return IW'(int'(yy) * winW + int'(xx));
  endfunction

  // ---------------------------------------------------------------------
  // Gradient at the current GRAD pixel. Neighbours are clamped at the patch
  // edges, so a border pixel differences against itself on that side.
  // ---------------------------------------------------------------------
  logic [XW-1:0] x_r, x_l;
  logic [YW-1:0] y_dn, y_up;

  always_comb begin
    x_r  = (x_q == X_LAST) ? x_q : x_q + XW'(1);
    x_l  = (x_q == '0)     ? x_q : x_q - XW'(1);
    y_dn = (y_q == Y_LAST) ? y_q : y_q + YW'(1);
    y_up = (y_q == '0)     ? y_q : y_q - YW'(1);
  end

  logic [dataW-1:0] p_r, p_l, p_dn, p_up;
  assign p_r  = patch_q[pidx(y_q,  x_r)];
  assign p_l  = patch_q[pidx(y_q,  x_l)];
  assign p_dn = patch_q[pidx(y_dn, x_q)];
  assign p_up = patch_q[pidx(y_up, x_q)];

  logic signed [dataW:0] dx, dy;
  logic        [dataW:0] adx, ady;
  logic        [MW-1:0]  mag;

  assign dx  = $signed({1'b0, p_r})  - $signed({1'b0, p_l});
  assign dy  = $signed({1'b0, p_dn}) - $signed({1'b0, p_up});
  assign adx = dx[dataW] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[dataW] ? $unsigned(-dy) : $unsigned(dy);
  assign mag = {1'b0, adx} + {1'b0, ady};

  // ---------------------------------------------------------------------
  // Orientation bin. y grows down the raster, so bin 2 means "pointing
  // down". Each quadrant is split at the 45-degree diagonal. A tie goes to
  // the odd bin. dx=dy=0 matches no quadrant and falls to bin 0 with zero
  // magnitude.
  // ---------------------------------------------------------------------
  logic       dx_pos, dx_neg, dy_pos, dy_neg;
  logic [2:0] bin;

  assign dx_neg = dx[dataW];
  assign dy_neg = dy[dataW];
  assign dx_pos = !dx[dataW] && (dx != '0);
  assign dy_pos = !dy[dataW] && (dy != '0);

  always_comb begin
    bin = 3'd0;
    if (dx_pos && !dy_neg)      bin = (ady < adx) ? 3'd0 : 3'd1;
    else if (!dx_pos && dy_pos) bin = (adx < ady) ? 3'd2 : 3'd3;
    else if (dx_neg && !dy_pos) bin = (ady < adx) ? 3'd4 : 3'd5;
    else if (!dx_neg && dy_neg) bin = (adx < ady) ? 3'd6 : 3'd7;
  end

  // Flat histogram slot: cell-major, then bin. This matches the descriptor
  // packing, so the descriptor copy is a direct concatenation.
  logic [HW-1:0] hsel;
  assign hsel = HW'(((int'(y_q) / cellW) * CX + int'(x_q) / cellW) * binN
                    + int'(bin));

  // The sum is one bit wider than either operand, so the saturation check
  // cannot overflow.
  logic [SW-1:0]    sum;
  logic [histW-1:0] hist_upd;
  assign sum      = SW'(hist_q[hsel]) + SW'(mag);
  assign hist_upd = (sum > SW'({histW{1'b1}})) ? {histW{1'b1}}
                                                : sum[histW-1:0];

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    desc_d  = desc_q;
    load_we = 1'b0;
    for (int i = 0; i < HN; i++) hist_d[i] = hist_q[i];

    if (start) begin
      // A restart from any state. A pixel offered in this cycle is dropped.
      // The previous descriptor stays visible until the next DONE.
      state_d = S_LOAD;
      idx_d   = '0;
      x_d     = '0;
      y_d     = '0;
      for (int i = 0; i < HN; i++) hist_d[i] = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (pix_valid) begin
            load_we = 1'b1;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = S_GRAD;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        S_GRAD: begin
          hist_d[hsel] = hist_upd;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = S_DONE;
              // Take hist_d so the last pixel's update is included in the
              // copy.
              for (int i = 0; i < HN; i++) desc_d[i*histW +: histW] = hist_d[i];
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      desc_q  <= '0;
      for (int i = 0; i < HN; i++) hist_q[i] <= '0;
    end else if (en) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      desc_q  <= desc_d;
      for (int i = 0; i < HN; i++) hist_q[i] <= hist_d[i];
    end
  end

  // Patch memory has no reset. GRAD reads it only after all N entries have
  // been written for the current patch.
  always_ff @(posedge clk) begin
    if (!rst && en && load_we) patch_q[idx_q] <= pix_in;
  end

  assign busy       = (state_q == S_LOAD) || (state_q == S_GRAD);
  assign desc_valid = (state_q == S_DONE);
  assign desc_out   = desc_q;

endmodule

// File: tb/tb_rotated_patch_orient_hist.sv
// Directed bench for rotated_patch_orient_hist. It drives two instances from
// the same inputs: the default 12-bit histogram build, and a 6-bit build
// whose bins saturate. Inputs are driven and outputs sampled on the falling
// clock edge.

module tb_rotated_patch_orient_hist;

  localparam int DW12 = 4 * 8 * 12;
  localparam int DW6  = 4 * 8 * 6;

  logic            clk = 1'b0;
  logic            rst, en, start, pix_valid;
  logic [7:0]      pix_in;
  logic            busy, desc_valid, busy6, desc_valid6;
  logic [DW12-1:0] desc_out;
  logic [DW6-1:0]  desc_out6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW12-1:0] exp_q[$];
  logic [DW12-1:0] exp6_q[$];

  // ------------------------------------------------------------ clock/reset
  always #5 clk = ~clk;

  rotated_patch_orient_hist u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .pix_valid(pix_valid),
    .pix_in(pix_in), .busy(busy), .desc_valid(desc_valid), .desc_out(desc_out)
  );

  rotated_patch_orient_hist #(.histW(6)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .start(start), .pix_valid(pix_valid),
    .pix_in(pix_in), .busy(busy6), .desc_valid(desc_valid6), .desc_out(desc_out6)
  );

  // ------------------------------------------------------------ helpers
  task automatic chk(input string tag, input logic [DW12-1:0] obs,
                     input logic [DW12-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Builds a descriptor in which every cell has value va in bin ba and value
  // vb in bin bb (bb = -1 means no second bin). Values are clipped to the
  // w-bit maximum.
  function automatic logic [DW12-1:0] mk(input int w, input int ba, input int va,
                                         input int bb, input int vb);
    logic [DW12-1:0] r;
    int hmax;
    int v;
    r    = '0;
    hmax = (1 << w) - 1;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 8; b++) begin
        v = 0;
        if (b == ba) v = va;
        if (b == bb) v = vb;
        if (v > hmax) v = hmax;
        if (w == 12) r[(c*8+b)*12 +: 12] = 12'(v);
        else         r[(c*8+b)*6  +: 6]  = 6'(v);
      end
    end
    return r;
  endfunction

  task automatic push_exp(input int ba, input int va, input int bb, input int vb);
    exp_q.push_back(mk(12, ba, va, bb, vb));
    exp6_q.push_back(mk(6, ba, va, bb, vb));
  endtask

  function automatic logic [7:0] pix_of(input int mode, input int x, input int y);
    case (mode)
      0:       return 8'h40;
      1:       return 8'(x * 16);
      2:       return 8'(y * 16);
      3:       return 8'(255 - x * 16);
      4:       return 8'(x * 80);
      default: return 8'(x * 16 + y * 16);
    endcase
  endfunction

  // ------------------------------------------------------------ drivers
  task automatic step();
    @(negedge clk);
  endtask

  // Pulse start with a garbage pixel alongside; that pixel must be dropped.
  task automatic do_start();
    en = 1'b1; start = 1'b1; pix_valid = 1'b1; pix_in = 8'hFF;
    step();
    start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic send_pixels(input int mode, input bit gaps);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        for (int g = 0; g < 3 && gaps && $urandom_range(0, 2) == 0; g++) begin
          // Idle cycle: either en=0 with a garbage pixel, or en=1 with no pixel.
          en        = 1'($urandom_range(0, 1));
          pix_valid = !en;
          pix_in    = 8'($urandom_range(0, 255));
          step();
        end
        en = 1'b1; pix_valid = 1'b1; pix_in = pix_of(mode, x, y);
        step();
      end
    end
    pix_valid = 1'b0;
  endtask

  // Waits for desc_valid while counting enabled edges after the last pixel.
  // On the first desc_valid it checks latency, busy and both descriptors,
  // then checks that the pulse stretches under en=0 and ends afterwards.
  task automatic wait_desc(input bit gaps, input string tag);
    int   cnt;
    bit   seen;
    logic prev_busy;
    logic [DW12-1:0] e, e6;
    cnt = 0; seen = 1'b0; prev_busy = busy;
    pix_valid = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      en = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (en) cnt++;
      if (desc_valid) seen = 1'b1;
      else prev_busy = busy;
    end
    chk({tag, "_seen"}, DW12'(seen), DW12'(1));
    if (seen) begin
      chk({tag, "_latency"}, DW12'(cnt + 1), DW12'(17));
      chk({tag, "_busy_drop"}, DW12'(busy), DW12'(0));
      chk({tag, "_busy_before"}, DW12'(prev_busy), DW12'(1));
      chk({tag, "_dv6"}, DW12'({busy6, desc_valid6}), DW12'(2'b01));
      e  = (exp_q.size()  > 0) ? exp_q.pop_front()  : '1;
      e6 = (exp6_q.size() > 0) ? exp6_q.pop_front() : '1;
      chk({tag, "_desc"}, desc_out, e);
      chk({tag, "_desc6"}, DW12'(desc_out6), e6);
      en = 1'b0;
      step();
      chk({tag, "_stretch"}, DW12'(desc_valid), DW12'(1));
      en = 1'b1;
      step();
      chk({tag, "_pulse_end"}, DW12'(desc_valid), DW12'(0));
    end
  endtask

  // ------------------------------------------------------------ sequence
  initial begin : main
    int dv_hits;
    rst = 1'b1; en = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    repeat (3) step();
    // Reset must act even with en low.
    chk("rst_busy", DW12'(busy), DW12'(0));
    chk("rst_desc_valid", DW12'(desc_valid), DW12'(0));
    chk("rst_desc_out", desc_out, '0);
    chk("rst_desc_out6", DW12'(desc_out6), '0);
    rst = 1'b0;

    // Constant patch: every gradient is zero.
    do_start();
    send_pixels(0, 1'b0);
    push_exp(0, 0, -1, 0);
    wait_desc(1'b0, "const");

    // Horizontal ramp: bin0 = 96 in every cell.
    do_start();
    send_pixels(1, 1'b0);
    push_exp(0, 96, -1, 0);
    wait_desc(1'b0, "ramp_x");

    // Vertical ramp: bin2 = 96.
    do_start();
    send_pixels(2, 1'b0);
    push_exp(2, 96, -1, 0);
    wait_desc(1'b0, "ramp_y");

    // Falling horizontal ramp: bin4 = 96.
    do_start();
    send_pixels(3, 1'b0);
    push_exp(4, 96, -1, 0);
    wait_desc(1'b0, "ramp_neg_x");

    // Steep ramp: 480 per cell; the 6-bit build saturates at 63.
    do_start();
    send_pixels(4, 1'b0);
    push_exp(0, 480, -1, 0);
    wait_desc(1'b0, "ramp_sat");

    // Diagonal p=16x+16y: ties |dx|==|dy| go to bin1; bin0=48, bin1=144 per cell.
    do_start();
    send_pixels(5, 1'b0);
    push_exp(0, 48, 1, 144);
    wait_desc(1'b0, "diag");

    // Abandoned load, restart mid-LOAD, then a gappy ramp load and gradient pass.
    do_start();
    en = 1'b1; pix_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix_in = 8'($urandom_range(0, 255));
      step();
    end
    chk("partial_busy", DW12'(busy), DW12'(1));
    do_start();
    send_pixels(1, 1'b1);
    push_exp(0, 96, -1, 0);
    wait_desc(1'b1, "gaps");

    // Reset in the middle of the gradient pass.
    do_start();
    send_pixels(2, 1'b0);
    en = 1'b1;
    repeat (5) step();
    chk("mid_grad_busy", DW12'(busy), DW12'(1));
    rst = 1'b1;
    step();
    chk("midrst_busy", DW12'(busy), DW12'(0));
    chk("midrst_desc_valid", DW12'(desc_valid), DW12'(0));
    chk("midrst_desc_out", desc_out, '0);
    chk("midrst_desc_out6", DW12'(desc_out6), '0);
    rst = 1'b0;
    dv_hits = 0;
    repeat (40) begin
      step();
      if (desc_valid || desc_valid6) dv_hits++;
    end
    chk("midrst_no_dv", DW12'(dv_hits), DW12'(0));
    chk("midrst_idle", DW12'(busy), DW12'(0));

    // A new patch completes, and its descriptor survives the next start.
    do_start();
    send_pixels(5, 1'b0);
    push_exp(0, 48, 1, 144);
    wait_desc(1'b0, "after_rst");
    do_start();
    chk("hold_desc", desc_out, mk(12, 0, 48, 1, 144));
    chk("hold_desc6", DW12'(desc_out6), mk(6, 0, 48, 1, 144));
    chk("hold_busy", DW12'(busy), DW12'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
